// File: rtl/electrode_drive_sequencer.sv
// Sequences the next-move generator, captures its electrode addresses and drives
// a 16-bit actuation mask for a programmable dwell with an all-off gap between moves.
module electrode_drive_sequencer #(
    parameter int DWELL_CYCLES  = 50000,
    parameter int GAP_CYCLES    = 1000,
    parameter int SETTLE_CYCLES = 2,
    parameter int MAX_MOVES     = 15
) (
    input  logic        clock,
    input  logic        reset_N,
    input  logic        start,
    input  logic        abort,
    input  logic        dropletSelect,
    input  logic [3:0]  A1,
    input  logic [3:0]  A2,
    input  logic [3:0]  A3,
    input  logic [3:0]  A4,
    input  logic        reachDest,
    output logic        gen_next,
    output logic        gen_init,
    output logic        gen_act,
    output logic [15:0] elec,
    output logic [3:0]  move_count,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [3:0] {
        IDLE,
        INIT,
        INIT_FALL,
        REQ,
        WAIT,
        LATCH,
        DRIVE,
        GAP,
        DONE,
        ERR
    } state_t;

    localparam logic [31:0] DWELL_LOAD  = 32'(DWELL_CYCLES - 1);
    localparam logic [31:0] GAP_LOAD    = (GAP_CYCLES > 0) ? 32'(GAP_CYCLES - 1) : 32'd0;
    localparam logic [3:0]  SETTLE_LOAD = 4'(SETTLE_CYCLES - 1);
    localparam logic [3:0]  MAX_MOVES_L = 4'(MAX_MOVES);

    // Generator outputs change on its own schedule, so every bit is double-flopped.
    logic [16:0] raw_in;
    logic [16:0] synced;

    assign raw_in = {reachDest, A4, A3, A2, A1};

    genvar gi;
    generate
        for (gi = 0; gi < 17; gi++) begin : g_sync
            logic s1_reg;
            logic s2_reg;
            always_ff @(posedge clock or negedge reset_N) begin
                if (!reset_N) begin
                    s1_reg <= 1'b0;
                    s2_reg <= 1'b0;
                end else begin
                    s1_reg <= raw_in[gi];
                    s2_reg <= s1_reg;
                end
            end
            assign synced[gi] = s2_reg;
        end
    endgenerate

    logic [3:0] a1_s;
    logic [3:0] a2_s;
    logic [3:0] a3_s;
    logic [3:0] a4_s;
    logic       reach_s;

    assign a1_s    = synced[3:0];
    assign a2_s    = synced[7:4];
    assign a3_s    = synced[11:8];
    assign a4_s    = synced[15:12];
    assign reach_s = synced[16];

    // One-hot decode; A3/A4 only contribute for a 4-electrode train.
    logic [15:0] mask;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_mask
            assign mask[gi] = (a1_s == 4'(gi)) || (a2_s == 4'(gi)) ||
                              (dropletSelect && ((a3_s == 4'(gi)) || (a4_s == 4'(gi))));
        end
    endgenerate

    state_t      state_reg, state_next;
    logic [3:0]  settle_cnt_reg, settle_cnt_next;
    logic [31:0] dwell_cnt_reg, dwell_cnt_next;
    logic [31:0] gap_cnt_reg, gap_cnt_next;
    logic [3:0]  move_count_reg, move_count_next;
    logic [15:0] elec_reg, elec_next;
    logic        gen_next_reg, gen_next_next;
    logic        gen_init_reg, gen_init_next;
    logic        gen_act_reg, gen_act_next;
    logic        busy_reg, busy_next;
    logic        done_reg, done_next;
    logic        err_reg, err_next;

    always_ff @(posedge clock or negedge reset_N) begin
        if (!reset_N) begin
            state_reg      <= IDLE;
            settle_cnt_reg <= 4'd0;
            dwell_cnt_reg  <= 32'd0;
            gap_cnt_reg    <= 32'd0;
            move_count_reg <= 4'd0;
            elec_reg       <= 16'd0;
            gen_next_reg   <= 1'b0;
            gen_init_reg   <= 1'b0;
            gen_act_reg    <= 1'b0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            state_reg      <= state_next;
            settle_cnt_reg <= settle_cnt_next;
            dwell_cnt_reg  <= dwell_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
            move_count_reg <= move_count_next;
            elec_reg       <= elec_next;
            gen_next_reg   <= gen_next_next;
            gen_init_reg   <= gen_init_next;
            gen_act_reg    <= gen_act_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            err_reg        <= err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        settle_cnt_next = settle_cnt_reg;
        dwell_cnt_next  = dwell_cnt_reg;
        gap_cnt_next    = gap_cnt_reg;
        move_count_next = move_count_reg;
        elec_next       = 16'd0;

        case (state_reg)
            IDLE, DONE, ERR: begin
                if (start) begin
                    state_next      = INIT;
                    move_count_next = 4'd0;
                end
            end
            INIT:      state_next = INIT_FALL;
            INIT_FALL: state_next = REQ;
            REQ: begin
                state_next      = WAIT;
                settle_cnt_next = SETTLE_LOAD;
            end
            WAIT: begin
                if (settle_cnt_reg == 4'd0) begin
                    state_next = LATCH;
                end else begin
                    settle_cnt_next = settle_cnt_reg - 4'd1;
                end
            end
            LATCH: begin
                if (reach_s) begin
                    state_next = DONE;
                end else if (move_count_reg >= MAX_MOVES_L) begin
                    state_next = ERR;
                end else begin
                    state_next      = DRIVE;
                    dwell_cnt_next  = DWELL_LOAD;
                    elec_next       = mask;
                    move_count_next = move_count_reg + 4'd1;
                end
            end
            DRIVE: begin
                if (dwell_cnt_reg == 32'd0) begin
                    if (GAP_CYCLES == 0) begin
                        state_next = REQ;
                    end else begin
                        state_next   = GAP;
                        gap_cnt_next = GAP_LOAD;
                    end
                end else begin
                    dwell_cnt_next = dwell_cnt_reg - 32'd1;
                    elec_next      = elec_reg;
                end
            end
            GAP: begin
                if (gap_cnt_reg == 32'd0) begin
                    state_next = REQ;
                end else begin
                    gap_cnt_next = gap_cnt_reg - 32'd1;
                end
            end
            default: state_next = IDLE;
        endcase

        // Abort beats start and any in-flight move; the move tally is kept for inspection.
        if (abort) begin
            state_next      = IDLE;
            elec_next       = 16'd0;
            move_count_next = move_count_reg;
        end
    end

    // Status/handshake outputs are registered images of the state being entered.
    always_comb begin
        gen_next_next = (state_next == INIT) || (state_next == REQ);
        gen_init_next = (state_next == INIT) || (state_next == INIT_FALL);
        gen_act_next  = !((state_next == IDLE) || (state_next == DONE) || (state_next == ERR));
        busy_next     = gen_act_next;
        done_next     = (state_next == DONE);
        err_next      = (state_next == ERR);
    end

    assign gen_next   = gen_next_reg;
    assign gen_init   = gen_init_reg;
    assign gen_act    = gen_act_reg;
    assign elec       = elec_reg;
    assign move_count = move_count_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;
    assign err        = err_reg;

endmodule

// File: doc/electrode_drive_sequencer.md
# electrode_drive_sequencer

Sits downstream of the next-move generator in the DMFB train-transport path. Sequences the generator by pulsing its `next` and init pins, and captures the A1–A4 electrode addresses it produces. Decodes those addresses into a 16-bit electrode actuation mask and holds the mask for a programmable dwell, with an all-off relaxation gap between moves. Stops when the generator reports `reachDest`, or flags an error if the move budget runs out.

## Interface
- DWELL_CYCLES, 50000, clock cycles each move's mask is driven (≥1)
- GAP_CYCLES, 1000, all-off cycles between moves (0 = no gap)
- SETTLE_CYCLES, 2, cycles waited after a `next` falling edge before sampling generator outputs (≥2)
- MAX_MOVES, 15, moves allowed before error (1..15)

Ports:
- clock  in  1  system clock, rising edge
- reset_N  in  1  asynchronous, active-low reset
- start  in  1  begin a transport; sampled in IDLE/DONE/ERR only
- abort  in  1  synchronous abort, highest priority after reset
- dropletSelect  in  1  1 = 4-electrode train (A1–A4), 0 = 2-electrode (A1, A2); also wired to generator
- A1, A2, A3, A4  in  4 each  electrode addresses from generator
- reachDest  in  1  generator destination flag
- gen_next  out  1  drives generator `next`; generator acts on its falling edge
- gen_init  out  1  drives generator init/reset pin (high = load src/dest)
- gen_act  out  1  drives generator activate pin
- elec  out  16  electrode actuation mask, bit i = electrode i
- move_count  out  4  moves driven since start
- busy, done, err  out  1 each  status

## Operation
- States: IDLE, INIT, INIT_FALL, REQ, WAIT, LATCH, DRIVE, GAP, DONE, ERR.
- IDLE: all outputs low. `start` → INIT; move_count ← 0.
- INIT: gen_init=1, gen_next=1, for 1 cycle → INIT_FALL.
- INIT_FALL: gen_init=1, gen_next=0, for 1 cycle. The falling edge loads the generator → REQ.
- REQ: gen_next=1, for 1 cycle → WAIT.
- WAIT: gen_next=0 for SETTLE_CYCLES cycles → LATCH.
- Capture: A1–A4 and reachDest pass through 2-flop synchronizers. They are sampled in LATCH only.
- LATCH, evaluated in priority order:
  - reachDest=1 → DONE.
  - else move_count==MAX_MOVES → ERR.
  - else elec ← mask, move_count += 1 → DRIVE.
- Mask: bit A1 | bit A2, plus bit A3 | bit A4 when dropletSelect=1. A3/A4 are ignored when dropletSelect=0, including the 4'b1111 sentinel. Duplicate addresses OR together.
- DRIVE: hold elec for DWELL_CYCLES cycles → GAP, with elec ← 0 on exit.
- GAP: elec=0 for GAP_CYCLES cycles → REQ. If GAP_CYCLES=0, DRIVE goes straight to REQ.
- DONE: elec=0, done=1, move_count held. `start` → INIT (restart).
- ERR: elec=0, err=1, move_count held. `start` → INIT (restart).
- gen_act=1 in every state except IDLE, DONE and ERR. busy=1 under the same condition.
- `start` while busy is ignored.
- `abort` in any state: next edge → IDLE, with elec=0, gen_next=0, gen_init=0, status cleared. move_count is held.
- reset_N low, at any time and asynchronously: state IDLE, every output 0, counters 0. A move in progress is dropped and no electrode stays energized.

## Timing
- Outputs are registered; there is no combinational path from inputs to outputs.
- `start` sampled at edge t gives:
  - gen_next high in cycle t+1 (INIT)
  - falling edge at t+2
  - second gen_next pulse at t+3
  - LATCH at t+4+SETTLE_CYCLES
  - elec valid from t+5+SETTLE_CYCLES
- Move period: 1 (REQ) + SETTLE_CYCLES + 1 (LATCH) + DWELL_CYCLES + GAP_CYCLES cycles.
- Pulse widths:
  - gen_next: exactly 1 cycle high per request.
  - gen_init: high for exactly 2 cycles, spanning the init falling edge.
- Counters: dwell and gap counters are 32-bit; the settle counter is 4-bit. All reload on state entry. move_count saturates at MAX_MOVES and never wraps.
- abort and start in the same cycle: abort wins.

## Test plan
- DWELL=4, GAP=2, SETTLE=2, 2-electrode mode, generator model src=3, dest=6:
  - required: elec sequence 0x0018, 0x0030, 0x0060, then done=1 with move_count=3.
  - each mask held exactly 4 cycles, with 2 zero cycles between masks.
- 4-electrode mode, src=0, dest=5, A=0,1,2,3 then 1,2,3,4:
  - required: elec = 0x000F, then 0x001E, then done=1.
  - A3/A4 = 4'b1111 in 2-electrode mode must not set bit 15.
- MAX_MOVES=2, reachDest never asserted → err=1 after the 2nd move; move_count=2, elec=0.
- abort asserted mid-DRIVE → next cycle elec=0, busy=0, state IDLE. A following `start` gives a fresh INIT with 2 gen_init cycles.
- reset_N low mid-WAIT, asynchronously → all outputs 0 immediately, not at the next edge.
- `start` pulsed again while busy → no extra gen_next pulses and no change to the move period.
